seq_muldiv: RTL and testbench
=============================

Name: seq_muldiv

Overview:
- Iterative unsigned multiply/divide unit in the integer datapath.
- Computes a 64-bit product, or a quotient and remainder, from two 32-bit operands over WIDTH iterations.
- Drives the Din and ld inputs of the two 32-bit load-enabled HI and LO result registers directly downstream of it.
- Does not store results architecturally; the HI/LO registers do that.

Parameters:
- WIDTH, 32: operand width. Also sets the iteration count.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  1  0 = multiply (a*b), 1 = divide (a/b).
- a  in  WIDTH  multiplicand or dividend.
- b  in  WIDTH  multiplier or divisor.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; results are valid in this cycle.
- hi_ld  out  1  load strobe for the HI register; equals done.
- lo_ld  out  1  load strobe for the LO register; equals done.
- hi_out  out  WIDTH  product[2*WIDTH-1:WIDTH] for multiply; remainder for divide.
- lo_out  out  WIDTH  product[WIDTH-1:0] for multiply; quotient for divide.
- div_by_zero  out  1  high with done when op=1 and b=0.

Behaviour:
- Reset (synchronous, active-high; clk):
  - State goes to IDLE and the counter clears.
  - busy, done, hi_ld, lo_ld and div_by_zero go to 0.
  - hi_out and lo_out go to 0.
  - Reset dominates start. Reset mid-operation abandons the operation and produces no done pulse.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: latch a, b and op, clear the counter, go to RUN.
  - Exception: divide with b=0 goes straight to DONE.
- RUN:
  - Performs one iteration per edge; the counter increments each edge.
  - When the edge completing iteration WIDTH arrives, go to DONE.
- DONE:
  - done, hi_ld and lo_ld are 1 for exactly one cycle.
  - Next edge returns to IDLE unconditionally.
  - start during DONE is ignored. Earliest back-to-back start is the cycle after DONE.
- Latency:
  - start sampled at edge E0.
  - busy is high after E0.
  - done is high in the cycle after edge E(WIDTH); for WIDTH=32 that is 33 cycles after start.
  - Divide by zero: done is high in the cycle after E0 (1 cycle).
- start while busy: ignored. The latched operands must not change.
- Multiply (shift-add, unsigned):
  - 2*WIDTH accumulator.
  - Per iteration: if the current multiplier LSB is 1, add the multiplicand into the upper half; then shift right by 1, with carry-in from the (WIDTH+1)-bit add.
  - No overflow is possible; the full product is returned.
- Divide (restoring, unsigned):
  - Per iteration: shift {rem, quot} left by 1; trial-subtract divisor from rem.
  - If no borrow, keep the difference and set the quotient LSB to 1; otherwise restore rem and leave the LSB at 0.
  - Subtract is WIDTH+1 bits wide so the borrow is explicit.
- Divide by zero: lo_out = all ones, hi_out = a, div_by_zero = 1. No iterations are run.
- Output hold:
  - hi_out and lo_out hold the last completed result until the next DONE or reset.
  - div_by_zero holds likewise.
- Operand edge cases (no special casing):
  - a=0 or b=0 in multiply gives 0.
  - a<b in divide gives quot 0, rem a.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings OP_MUL=1'b0 and OP_DIV=1'b1;
  - state encodings IDLE, RUN, DONE;
  - default WIDTH constant.
- One natural sub-module, muldiv_ctrl: the FSM plus iteration counter. It outputs busy, done, iteration enable and load-operands strobes.
- The arithmetic datapath stays in seq_muldiv.

Test Plan:
- mul a=7, b=6 → done exactly 33 cycles after start; lo_out=42, hi_out=0; hi_ld=lo_ld=1 for one cycle.
- mul a=32'hFFFFFFFF, b=32'hFFFFFFFF → hi_out=32'hFFFFFFFE, lo_out=32'h00000001.
- div a=100, b=7 → lo_out=14, hi_out=2, div_by_zero=0.
- div a=32'h12345678, b=0 → done 1 cycle after start; lo_out=32'hFFFFFFFF, hi_out=32'h12345678, div_by_zero=1.
- start mul 3*5, then start with a=9, b=9 at cycle 10 → ignored; result 15 after 33 cycles; only one done pulse.
- reset asserted at cycle 20 of a multiply → next cycle busy=0, hi_out=lo_out=0, no done. A new start of 2*2 then yields lo_out=4.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer for seq_muldiv: three-state FSM plus iteration counter.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; operands are captured on the start edge
//   RUN   | one shift-add / restoring-divide iteration per edge
//   DONE  | results valid, one-cycle done/load pulse, then back to IDLE
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div_zero,
  output logic busy,
  output logic done,
  output logic iter_en,
  output logic last_iter,
  output logic load,
  output logic load_dbz
);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, counter update and strobes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    done      = 1'b0;
    iter_en   = 1'b0;
    last_iter = 1'b0;
    load      = 1'b0;
    load_dbz  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_nxt = '0;
          // A zero divisor skips the iterations entirely.
          if (div_zero) begin
            load_dbz  = 1'b1;
            state_nxt = DONE;
          end else begin
            load      = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        busy    = 1'b1;
        iter_en = 1'b1;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last_iter = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiply/divide feeding the HI/LO result registers.
module seq_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             hi_ld,
  output logic             lo_ld,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_by_zero
);

  logic             div_zero, iter_en, last_iter, load, load_dbz;
  logic             op_reg;
  logic [WIDTH-1:0] opnd, acc_hi, acc_lo, hi_nxt, lo_nxt;
  logic [WIDTH:0]   mul_sum, div_trial, div_diff;

  assign div_zero = (op == OP_DIV) && (b == '0);

  muldiv_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .div_zero  (div_zero),
    .busy      (busy),
    .done      (done),
    .iter_en   (iter_en),
    .last_iter (last_iter),
    .load      (load),
    .load_dbz  (load_dbz)
  );

  assign hi_ld = done;
  assign lo_ld = done;

  // One iteration of shift-add multiply or restoring divide.
  // acc_hi holds the upper product half / partial remainder,
  // acc_lo holds the multiplier being shifted out / quotient being shifted in.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};
    div_trial = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opnd};
    if (op_reg == OP_DIV) begin
      if (!div_diff[WIDTH]) begin
        hi_nxt = div_diff[WIDTH-1:0];
        lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = div_trial[WIDTH-1:0];
        lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Operand capture and iteration accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg <= OP_MUL;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else if (load) begin
      op_reg <= op;
      opnd   <= (op == OP_DIV) ? b : a;
      acc_hi <= '0;
      acc_lo <= (op == OP_DIV) ? a : b;
    end else if (iter_en) begin
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
    end
  end

  // Result registers: updated on entry to DONE, held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_out      <= '0;
      lo_out      <= '0;
      div_by_zero <= 1'b0;
    end else if (load_dbz) begin
      hi_out      <= a;
      lo_out      <= '1;
      div_by_zero <= 1'b1;
    end else if (last_iter) begin
      hi_out      <= hi_nxt;
      lo_out      <= lo_nxt;
      div_by_zero <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_muldiv.sv
// Self-checking bench for seq_muldiv with a queue-based scoreboard.
module tb_seq_muldiv;

  logic        clk, reset, start, op;
  logic [31:0] a, b;
  logic        busy, done, hi_ld, lo_ld, div_by_zero;
  logic [31:0] hi_out, lo_out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  seq_muldiv dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi_ld       (hi_ld),
    .lo_ld       (lo_ld),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] p;
    if (o == 1'b0) begin
      p     = {32'd0, x} * {32'd0, y};
      e.hi  = p[63:32];
      e.lo  = p[31:0];
      e.dbz = 1'b0;
    end else if (y == 32'd0) begin
      e.hi  = x;
      e.lo  = 32'hFFFF_FFFF;
      e.dbz = 1'b1;
    end else begin
      e.hi  = x % y;
      e.lo  = x / y;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Drive a one-cycle start; returns at the first negedge after the sampling edge.
  task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    sb.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
  endtask

  // Waits (bounded) for done; cyc is the cycle index after the start edge.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd4;
    repeat (3) @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0 || hi_ld !== 1'b0 || lo_ld !== 1'b0) begin
      bad++; $display("FAIL reset_strobes got=%b%b%b exp=000", done, hi_ld, lo_ld); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    total++; if (hi_out !== 32'd0 || lo_out !== 32'd0) begin
      bad++; $display("FAIL reset_out got=%h_%h exp=0_0", hi_out, lo_out); end
  endtask

  task automatic test_mul_basic;
    int   cyc;
    exp_t e;
    issue(1'b0, 32'd7, 32'd6);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mul_busy got=%b exp=1", busy); end
    wait_done(cyc);
    total++; if (cyc !== 33) begin bad++; $display("FAIL mul_latency got=%0d exp=33", cyc); end
    total++; if (hi_ld !== 1'b1 || lo_ld !== 1'b1) begin
      bad++; $display("FAIL mul_ld got=%b%b exp=11", hi_ld, lo_ld); end
    e = sb.pop_front();
    total++; if (lo_out !== e.lo || hi_out !== e.hi) begin
      bad++; $display("FAIL mul_7x6 got=%h_%h exp=%h_%h", hi_out, lo_out, e.hi, e.lo); end
    @(negedge clk);
    total++; if (done !== 1'b0 || hi_ld !== 1'b0 || lo_ld !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL mul_pulse got=%b%b%b%b exp=0000", done, hi_ld, lo_ld, busy); end
    repeat (3) @(negedge clk);
    total++; if (lo_out !== 32'd42 || hi_out !== 32'd0) begin
      bad++; $display("FAIL mul_hold got=%h_%h exp=0_2a", hi_out, lo_out); end
  endtask

  task automatic test_mul_max;
    int   cyc;
    exp_t e;
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc);
    e = sb.pop_front();
    total++; if (cyc !== 33 || hi_out !== e.hi || lo_out !== e.lo) begin
      bad++; $display("FAIL mul_max got=%0d:%h_%h exp=33:%h_%h", cyc, hi_out, lo_out, e.hi, e.lo); end
    issue(1'b0, 32'd0, 32'h1234_5678);
    wait_done(cyc);
    e = sb.pop_front();
    total++; if (hi_out !== e.hi || lo_out !== e.lo) begin
      bad++; $display("FAIL mul_zero got=%h_%h exp=%h_%h", hi_out, lo_out, e.hi, e.lo); end
  endtask

  task automatic test_div_basic;
    int   cyc;
    exp_t e;
    issue(1'b1, 32'd100, 32'd7);
    wait_done(cyc);
    e = sb.pop_front();
    total++; if (cyc !== 33) begin bad++; $display("FAIL div_latency got=%0d exp=33", cyc); end
    total++; if (lo_out !== e.lo || hi_out !== e.hi || div_by_zero !== e.dbz) begin
      bad++; $display("FAIL div_100_7 got=%h_%h_%b exp=%h_%h_%b", hi_out, lo_out, div_by_zero, e.hi, e.lo, e.dbz); end
    issue(1'b1, 32'd5, 32'd9);
    wait_done(cyc);
    e = sb.pop_front();
    total++; if (lo_out !== e.lo || hi_out !== e.hi) begin
      bad++; $display("FAIL div_small got=%h_%h exp=%h_%h", hi_out, lo_out, e.hi, e.lo); end
    issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc);
    e = sb.pop_front();
    total++; if (lo_out !== e.lo || hi_out !== e.hi) begin
      bad++; $display("FAIL div_max got=%h_%h exp=%h_%h", hi_out, lo_out, e.hi, e.lo); end
  endtask

  task automatic test_div_zero;
    int   cyc;
    exp_t e;
    issue(1'b1, 32'h1234_5678, 32'd0);
    wait_done(cyc);
    e = sb.pop_front();
    total++; if (cyc !== 1) begin bad++; $display("FAIL dbz_latency got=%0d exp=1", cyc); end
    total++; if (lo_out !== e.lo || hi_out !== e.hi || div_by_zero !== 1'b1) begin
      bad++; $display("FAIL dbz_result got=%h_%h_%b exp=%h_%h_1", hi_out, lo_out, div_by_zero, e.hi, e.lo); end
    repeat (2) @(negedge clk);
    total++; if (div_by_zero !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL dbz_hold got=%b_%b exp=1_0", div_by_zero, busy); end
  endtask

  task automatic test_start_while_busy;
    int   ndone = 0;
    int   first = 0;
    exp_t e;
    issue(1'b0, 32'd3, 32'd5);
    for (int c = 1; c <= 45; c++) begin
      if (done === 1'b1) begin
        ndone++;
        if (first == 0) begin
          first = c;
          e = sb.pop_front();
          total++; if (lo_out !== e.lo || hi_out !== e.hi) begin
            bad++; $display("FAIL busy_result got=%h_%h exp=%h_%h", hi_out, lo_out, e.hi, e.lo); end
        end
      end
      if (c == 10) begin
        op = 1'b0; a = 32'd9; b = 32'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    total++; if (first !== 33 || ndone !== 1) begin
      bad++; $display("FAIL busy_ignore got=first%0d/n%0d exp=first33/n1", first, ndone); end
  endtask

  task automatic test_reset_mid;
    int   cyc;
    bit   seen = 1'b0;
    exp_t e;
    exp_t dropped;
    issue(1'b0, 32'd1234, 32'd5678);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dropped = sb.pop_back();
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL rstmid_ctrl got=%b%b exp=00", busy, done); end
    total++; if (hi_out !== 32'd0 || lo_out !== 32'd0) begin
      bad++; $display("FAIL rstmid_out got=%h_%h exp=0_0", hi_out, lo_out); end
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_nodone got=%b exp=0 (dropped lo=%h)", seen, dropped.lo); end
    issue(1'b0, 32'd2, 32'd2);
    wait_done(cyc);
    e = sb.pop_front();
    total++; if (cyc !== 33 || lo_out !== e.lo || hi_out !== e.hi) begin
      bad++; $display("FAIL rstmid_after got=%0d:%h_%h exp=33:%h_%h", cyc, hi_out, lo_out, e.hi, e.lo); end
  endtask

  task automatic test_back_to_back;
    int          cyc;
    exp_t        e;
    logic        o;
    logic [31:0] x, y;
    issue(1'b0, 32'd11, 32'd13);
    wait_done(cyc);
    e = sb.pop_front();
    total++; if (lo_out !== e.lo || hi_out !== e.hi) begin
      bad++; $display("FAIL b2b_first got=%h_%h exp=%h_%h", hi_out, lo_out, e.hi, e.lo); end
    // start raised during DONE must be ignored; held into the IDLE cycle it is taken
    op = 1'b1; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_done_start got=%b exp=0", busy); end
    sb.push_back(model(1'b1, 32'd1000, 32'd3));
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_idle_start got=%b exp=1", busy); end
    wait_done(cyc);
    e = sb.pop_front();
    total++; if (cyc !== 33 || lo_out !== e.lo || hi_out !== e.hi) begin
      bad++; $display("FAIL b2b_second got=%0d:%h_%h exp=33:%h_%h", cyc, hi_out, lo_out, e.hi, e.lo); end
    for (int i = 0; i < 10; i++) begin
      o = 1'($urandom_range(0, 1));
      x = $urandom;
      y = (o && $urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 40)) : $urandom;
      issue(o, x, y);
      wait_done(cyc);
      e = sb.pop_front();
      total++; if (cyc !== 33 || lo_out !== e.lo || hi_out !== e.hi || div_by_zero !== e.dbz) begin
        bad++; $display("FAIL b2b_rand%0d op=%b a=%h b=%h got=%0d:%h_%h exp=33:%h_%h", i, o, x, y, cyc, hi_out, lo_out, e.hi, e.lo); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    test_reset();
    test_mul_basic();
    test_mul_max();
    test_div_basic();
    test_div_zero();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
